// File: rtl/inert_spi_seq_if.sv
// inert_spi_seq_if: sequencer <-> SPI monarch and sample output bundle.
// master is the sequencer side, slave is the SPI/sensor/filter side.
interface inert_spi_seq_if;
    logic        INT;
    logic        done;
    logic [15:0] resp;
    logic        snd;
    logic [15:0] cmd;
    logic [15:0] yaw_rt;
    logic [15:0] az;
    logic        vld;

    modport master (
        input  INT, done, resp,
        output snd, cmd, yaw_rt, az, vld
    );

    modport slave (
        output INT, done, resp,
        input  snd, cmd, yaw_rt, az, vld
    );
endinterface

// File: rtl/inert_spi_seq.sv
// inert_spi_seq: configures the 6-axis sensor after power-up, then on each
// data-ready reads yaw rate and Z accel over SPI and presents 16-bit samples.
module inert_spi_seq #(
    parameter int INIT_BITS = 16
) (
    input logic             clk,
    input logic             rst_n,
    inert_spi_seq_if.master bus
);
    typedef enum logic [2:0] {
        INIT_WAIT,
        CFG_SEND,
        CFG_WAIT,
        WAIT_INT,
        RD_SEND,
        RD_WAIT,
        VALID
    } state_t;

    state_t               state;
    logic [INIT_BITS-1:0] timer;
    logic [1:0]           idx;
    logic [1:0]           int_sync;
    logic                 done_q;
    logic                 done_rise;
    logic [7:0]           hold [4];
    logic                 unused_resp_hi;

    // A done left high from the previous transfer must not count again.
    assign done_rise      = bus.done & ~done_q;
    assign unused_resp_hi = ^bus.resp[15:8];

    function automatic logic [15:0] cfg_word(input logic [1:0] i);
        logic [15:0] w;
        unique case (i)
            2'd0: w = 16'h0D02;
            2'd1: w = 16'h1053;
            2'd2: w = 16'h1150;
            2'd3: w = 16'h1460;
        endcase
        return w;
    endfunction

    function automatic logic [15:0] rd_word(input logic [1:0] i);
        logic [15:0] w;
        unique case (i)
            2'd0: w = 16'hA600;
            2'd1: w = 16'hA700;
            2'd2: w = 16'hAC00;
            2'd3: w = 16'hAD00;
        endcase
        return w;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= INIT_WAIT;
            timer      <= '0;
            idx        <= '0;
            int_sync   <= '0;
            done_q     <= 1'b0;
            bus.snd    <= 1'b0;
            bus.vld    <= 1'b0;
            bus.cmd    <= '0;
            bus.yaw_rt <= '0;
            bus.az     <= '0;
            for (int i = 0; i < 4; i++) hold[i] <= '0;
        end else begin
            int_sync <= {int_sync[0], bus.INT};
            done_q   <= bus.done;
            bus.snd  <= 1'b0;
            bus.vld  <= 1'b0;
            unique case (state)
                INIT_WAIT: begin
                    // Timer stops at all-ones so it can never re-trigger.
                    if (&timer) begin
                        state <= CFG_SEND;
                        idx   <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                CFG_SEND: begin
                    bus.cmd <= cfg_word(idx);
                    bus.snd <= 1'b1;
                    state   <= CFG_WAIT;
                end
                CFG_WAIT: begin
                    if (done_rise) begin
                        if (idx == 2'd3) begin
                            state <= WAIT_INT;
                            idx   <= '0;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= CFG_SEND;
                        end
                    end
                end
                WAIT_INT: begin
                    if (int_sync[1]) state <= RD_SEND;
                end
                RD_SEND: begin
                    bus.cmd <= rd_word(idx);
                    bus.snd <= 1'b1;
                    state   <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (done_rise) begin
                        hold[idx] <= bus.resp[7:0];
                        if (idx == 2'd3) begin
                            state <= VALID;
                            idx   <= '0;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= RD_SEND;
                        end
                    end
                end
                VALID: begin
                    bus.yaw_rt <= {hold[1], hold[0]};
                    bus.az     <= {hold[3], hold[2]};
                    bus.vld    <= 1'b1;
                    state      <= WAIT_INT;
                end
                default: state <= INIT_WAIT;
            endcase
        end
    end
endmodule
